parking_lot_occupancy_fsm: RTL and testbench

- Sits directly downstream of the two input debouncers, one per sensor.
- Consumes the debounced outer sensor (a) and inner sensor (b) of the lot gate.
- Recognises complete car-entry and car-exit sensor sequences and emits one-cycle pulses for each.
- Maintains a saturating occupancy count with full/empty flags for the display/LED stage.

---
 rtl/parking_lot_occupancy_fsm.sv | 140 ++++++++++++++
 tb/tb_parking_lot_occupancy_fsm.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/parking_lot_occupancy_fsm.sv
// Gate-sensor sequence recogniser with saturating occupancy counter.
// Optional stalled-sequence abort is built when PLOT_TIMEOUT_EN is defined.
module parking_lot_occupancy_fsm #(
  parameter int CAPACITY       = 15,
  parameter int CNT_W          = $clog2(CAPACITY+1),
  parameter int TIMEOUT_CYCLES = 200_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  output logic             car_enter,
  output logic             car_exit,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             err,
  output logic             seq_abort
);

  typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3} state_t;

  localparam logic [CNT_W-1:0] LP_CAP = CNT_W'(CAPACITY);

  state_t           r_state, w_next;
  logic [1:0]       w_ab;
  logic             w_enter, w_exit, w_tmo, w_err;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_ab = {a, b};

  always_comb begin
    w_next  = r_state;
    w_enter = 1'b0;
    w_exit  = 1'b0;
    case (r_state)
      IDLE: case (w_ab)
        2'b10:   w_next = EN1;
        2'b01:   w_next = EX1;
        default: w_next = IDLE;
      endcase
      EN1: case (w_ab)
        2'b10:   w_next = EN1;
        2'b11:   w_next = EN2;
        default: w_next = IDLE;
      endcase
      EN2: case (w_ab)
        2'b01:   w_next = EN3;
        2'b10:   w_next = EN1;
        2'b00:   w_next = IDLE;
        default: w_next = EN2;
      endcase
      EN3: case (w_ab)
        2'b00:   begin w_next = IDLE; w_enter = 1'b1; end
        2'b11:   w_next = EN2;
        2'b10:   w_next = IDLE;
        default: w_next = EN3;
      endcase
      EX1: case (w_ab)
        2'b01:   w_next = EX1;
        2'b11:   w_next = EX2;
        default: w_next = IDLE;
      endcase
      EX2: case (w_ab)
        2'b10:   w_next = EX3;
        2'b01:   w_next = EX1;
        2'b00:   w_next = IDLE;
        default: w_next = EX2;
      endcase
      EX3: case (w_ab)
        2'b00:   begin w_next = IDLE; w_exit = 1'b1; end
        2'b11:   w_next = EX2;
        2'b01:   w_next = IDLE;
        default: w_next = EX3;
      endcase
      default: w_next = IDLE;
    endcase
    // A timeout wins over any transition, including a completing one.
    if (w_tmo) begin
      w_next  = IDLE;
      w_enter = 1'b0;
      w_exit  = 1'b0;
    end
  end

  always_comb begin
    w_cnt_nxt = count;
    w_err     = 1'b0;
    if (w_enter) begin
      if (count == LP_CAP) w_err = 1'b1;
      else                 w_cnt_nxt = count + 1'b1;
    end else if (w_exit) begin
      if (count == '0) w_err = 1'b1;
      else             w_cnt_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      car_enter <= 1'b0;
      car_exit  <= 1'b0;
      err       <= 1'b0;
    end else begin
      r_state   <= w_next;
      count     <= w_cnt_nxt;
      full      <= (w_cnt_nxt == LP_CAP);
      empty     <= (w_cnt_nxt == '0);
      car_enter <= w_enter;
      car_exit  <= w_exit;
      err       <= w_err;
    end
  end

`ifdef PLOT_TIMEOUT_EN
  logic [31:0] r_stall;
  logic        r_abort;

  assign w_tmo     = (r_state != IDLE) && (r_stall == 32'(TIMEOUT_CYCLES-1));
  assign seq_abort = r_abort;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall <= '0;
      r_abort <= 1'b0;
    end else begin
      r_abort <= w_tmo;
      if (w_tmo || r_state == IDLE || w_next != r_state) r_stall <= '0;
      else                                               r_stall <= r_stall + 32'd1;
    end
  end
`else
  assign w_tmo     = 1'b0;
  assign seq_abort = 1'b0 & (TIMEOUT_CYCLES < 1);
`endif

endmodule

// File: tb/tb_parking_lot_occupancy_fsm.sv
// Directed + randomized bench for parking_lot_occupancy_fsm, checked against
// a path-progress reference model (CAPACITY=3, TIMEOUT_CYCLES=16).
module tb_parking_lot_occupancy_fsm;
  localparam int CAP = 3;
  localparam int TMO = 16;
  localparam int CW  = $clog2(CAP+1);

  logic clk = 1'b0;
  logic reset, a, b;
  logic car_enter, car_exit, full, empty, err, seq_abort;
  logic [CW-1:0] count;

  parking_lot_occupancy_fsm #(.CAPACITY(CAP), .CNT_W(CW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .car_enter(car_enter), .car_exit(car_exit), .count(count),
    .full(full), .empty(empty), .err(err), .seq_abort(seq_abort)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int n_enter = 0, n_exit = 0, n_err = 0, n_abort = 0;

  // Model: m_pos = progress along a path (+1..+3 entry, -1..-3 exit, 0 idle).
  int m_pos, m_cnt, m_stall;
  bit m_enter, m_exit, m_err, m_abort;

  function automatic int stage(input bit ent, input logic [1:0] ab);
    if (ent) return (ab == 2'b10) ? 1 : (ab == 2'b11) ? 2 : (ab == 2'b01) ? 3 : 0;
    else     return (ab == 2'b01) ? 1 : (ab == 2'b11) ? 2 : (ab == 2'b10) ? 3 : 0;
  endfunction

  task automatic model_reset();
    m_pos = 0; m_cnt = 0; m_stall = 0;
    m_enter = 0; m_exit = 0; m_err = 0; m_abort = 0;
  endtask

  task automatic model_step(input logic [1:0] ab);
    int p, s, np;
    bit ent;
    m_enter = 0; m_exit = 0; m_err = 0; m_abort = 0;
`ifdef PLOT_TIMEOUT_EN
    if (m_pos != 0 && m_stall == TMO-1) begin
      m_pos = 0; m_stall = 0; m_abort = 1;
      return;
    end
`endif
    if (m_pos == 0) np = (ab == 2'b10) ? 1 : (ab == 2'b01) ? -1 : 0;
    else begin
      ent = (m_pos > 0);
      p   = ent ? m_pos : -m_pos;
      s   = stage(ent, ab);
      if (s == 0) begin
        np = 0;
        if (p == 3) begin
          if (ent) begin
            m_enter = 1;
            if (m_cnt == CAP) m_err = 1; else m_cnt++;
          end else begin
            m_exit = 1;
            if (m_cnt == 0) m_err = 1; else m_cnt--;
          end
        end
      end else if (s >= p-1 && s <= p+1) np = ent ? s : -s;
      else np = 0;
    end
    if (np == 0 || np != m_pos) m_stall = 0; else m_stall++;
    m_pos = np;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("car_enter", {31'd0, car_enter}, {31'd0, m_enter});
    chk("car_exit",  {31'd0, car_exit},  {31'd0, m_exit});
    chk("count",     32'(count),         32'(m_cnt));
    chk("full",      {31'd0, full},      {31'd0, m_cnt == CAP});
    chk("empty",     {31'd0, empty},     {31'd0, m_cnt == 0});
    chk("err",       {31'd0, err},       {31'd0, m_err});
    chk("seq_abort", {31'd0, seq_abort}, {31'd0, m_abort});
  endtask

  task automatic step(input logic [1:0] ab);
    {a, b} = ab;
    @(posedge clk);
    model_step(ab);
    @(negedge clk);
    if (car_enter === 1'b1) n_enter++;
    if (car_exit  === 1'b1) n_exit++;
    if (err       === 1'b1) n_err++;
    if (seq_abort === 1'b1) n_abort++;
    check_all();
  endtask

  task automatic hold(input logic [1:0] ab, input int n);
    repeat (n) step(ab);
  endtask

  task automatic do_reset();
    reset = 1'b0; a = 1'b0; b = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    check_all();
    reset = 1'b1;
  endtask

  task automatic entry(input int n);
    hold(2'b10, n); hold(2'b11, n); hold(2'b01, n); hold(2'b00, n);
  endtask

  task automatic leave(input int n);
    hold(2'b01, n); hold(2'b11, n); hold(2'b10, n); hold(2'b00, n);
  endtask

  // One possibly-corrupted sequence with random hold lengths.
  task automatic rand_seq();
    logic [1:0] seq [4];
    bit ent;
    ent = $urandom_range(1);
    seq[0] = ent ? 2'b10 : 2'b01; seq[1] = 2'b11;
    seq[2] = ent ? 2'b01 : 2'b10; seq[3] = 2'b00;
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(9) == 0) hold(2'($urandom_range(3)), $urandom_range(1, 3));
      else                         hold(seq[i], $urandom_range(1, 3));
    end
  endtask

  initial begin
    int e0;
    do_reset();
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", {31'd0, empty}, 1);
    chk("rst_full",  {31'd0, full},  0);

    // basic entry then exit
    hold(2'b00, 5); entry(5);
    chk("entry_pulses", n_enter, 1);
    chk("entry_count", 32'(count), 1);
    chk("entry_empty", {31'd0, empty}, 0);
    chk("entry_err", n_err, 0);
    hold(2'b00, 5); leave(5);
    chk("exit_pulses", n_exit, 1);
    chk("exit_count", 32'(count), 0);
    chk("exit_empty", {31'd0, empty}, 1);

    // aborted entries
    hold(2'b10, 3); hold(2'b11, 3); hold(2'b10, 3); hold(2'b00, 3);
    hold(2'b10, 3); hold(2'b01, 3); hold(2'b00, 3);
    chk("abort_pulses", n_enter + n_exit, 2);
    chk("abort_count", 32'(count), 0);

    // saturation high then low
    repeat (4) entry(2);
    chk("sat_count", 32'(count), CAP);
    chk("sat_full", {31'd0, full}, 1);
    chk("sat_err", n_err, 1);
    chk("sat_pulses", n_enter, 5);
    repeat (4) leave(2);
    chk("under_count", 32'(count), 0);
    chk("under_err", n_err, 2);

    // reset mid-sequence
    entry(1); hold(2'b10, 2); hold(2'b11, 2);
    do_reset();
    e0 = n_enter;
    hold(2'b00, 2);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_pulses", n_enter - e0, 0);
    entry(2);
    chk("postrst_count", 32'(count), 1);

`ifdef PLOT_TIMEOUT_EN
    e0 = n_enter;
    hold(2'b00, 2); hold(2'b10, 2); hold(2'b11, 20);
    chk("tmo_aborts", n_abort, 1);
    hold(2'b01, 3); hold(2'b00, 3);
    chk("tmo_no_enter", n_enter - e0, 0);
`endif

    for (int i = 0; i < 400; i++) rand_seq();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
